uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_serializer.sv | 95 +++++++++
 rtl/uart_tx_arbiter.sv | 55 +++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants, serializer state encoding and bit-timing helpers.
// Used by the interface, the serializer and the arbiter top.
package uart_pkg;

  typedef enum logic [1:0] {
    START = 2'b00,
    DATA  = 2'b01,
    STOP  = 2'b10,
    IDLE  = 2'b11
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int bit_cycles(input int f, input int baud);
    return f / baud;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-facing bundle: two byte-send handshakes plus the serial line and status.
// master = requesters side, slave = arbiter side.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic                 req0;
  logic                 req1;
  logic [DATA_BITS-1:0] data0;
  logic [DATA_BITS-1:0] data1;
  logic                 ack0;
  logic                 ack1;
  logic                 tx;
  logic                 busy;
  logic                 grant_id;

  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, tx, busy, grant_id
  );

  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, tx, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start pulse in IDLE latches data; tx goes low on the next cycle.
// No backpressure beyond busy: start is ignored until the frame has returned to IDLE.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 tx
);

  localparam int            BIT_CYCLES = bit_cycles(F, BAUD);
  localparam int            CW         = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC   = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  assign bit_end = (baud_cnt == LAST_CYC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= data;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // 3-bit counter wraps back to 0 as the last data bit ends
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_DATA) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx    <= shreg[1];
              shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for one UART transmitter; ack is 1 cycle after req.
// Requests wait while a frame is in flight and are only granted from an idle serializer.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  logic                 ser_busy;
  logic                 start;
  logic                 grant;
  logic                 last_grant;
  logic [DATA_BITS-1:0] grant_data;

  assign start      = (bus.req0 | bus.req1) & ~ser_busy;
  // Contention goes to whoever lost last time; a lone requester always wins.
  assign grant      = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
  assign grant_data = grant ? bus.data1 : bus.data0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.grant_id <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      bus.ack0 <= start & ~grant;
      bus.ack1 <= start & grant;
      if (start) begin
        bus.grant_id <= grant;
        last_grant   <= grant;
      end
    end
  end

  uart_tx_serializer #(
    .BAUD (BAUD),
    .F    (F)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (grant_data),
    .busy  (ser_busy),
    .tx    (bus.tx)
  );

  assign bus.busy = ser_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART receiver monitor plus a round-robin queue model.
module tb_uart_tx_arbiter;

  localparam int BAUD  = 115200;
  localparam int F     = 50000000;
  localparam int BC    = F / BAUD;
  localparam int FRAME = 10 * BC + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.BAUD(BAUD), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver-side monitor: decodes frames from tx by mid-bit sampling.
  logic [7:0] rx_byte[$];
  logic       rx_id[$];
  int         rx_start[$];
  int   ack0_cnt = 0, ack1_cnt = 0, ack_both = 0, ack_long = 0;
  logic prev_tx = 1'b1, prev_a0 = 1'b0, prev_a1 = 1'b0;
  bit   mon_on = 1'b0;
  int   mon_cnt = 0, mon_start = 0, mon_k = 0;
  logic [7:0] mon_byte = 8'h00;
  logic mon_id = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_on  = 1'b0;
      prev_tx = 1'b1;
      prev_a0 = 1'b0;
      prev_a1 = 1'b0;
    end else begin
      if (bus.ack0) ack0_cnt++;
      if (bus.ack1) ack1_cnt++;
      if (bus.ack0 && bus.ack1) ack_both++;
      if ((bus.ack0 && prev_a0) || (bus.ack1 && prev_a1)) ack_long++;
      if (!mon_on) begin
        if (prev_tx && !bus.tx) begin
          mon_on    = 1'b1;
          mon_cnt   = 0;
          mon_id    = bus.grant_id;
          mon_start = cyc;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_on && (mon_cnt % BC) == BC / 2) begin
        mon_k = mon_cnt / BC;
        if (mon_k == 0 && bus.tx !== 1'b0) mon_on = 1'b0;
        else if (mon_k >= 1 && mon_k <= 8) mon_byte = {bus.tx, mon_byte[7:1]};
        else if (mon_k == 9) begin
          if (bus.tx === 1'b1) begin
            rx_byte.push_back(mon_byte);
            rx_id.push_back(mon_id);
            rx_start.push_back(mon_start);
          end
          mon_on = 1'b0;
        end
      end
      prev_tx = bus.tx;
      prev_a0 = bus.ack0;
      prev_a1 = bus.ack1;
    end
  end

  // Pending bytes per requester, and the frames the model expects in order.
  logic [7:0] q0[$], q1[$], exp_byte[$];
  logic       exp_id[$];

  task automatic do_reset();
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int limit, output bit to);
    to = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!bus.busy) begin
        to = 1'b0;
        return;
      end
    end
  endtask

  // Requesters hold req with the head of their queue until acked, then move on.
  task automatic run_requesters(input int limit, output bit to);
    to = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (bus.ack0 && q0.size() > 0) void'(q0.pop_front());
      if (bus.ack1 && q1.size() > 0) void'(q1.pop_front());
      bus.req0 = (q0.size() > 0);
      bus.req1 = (q1.size() > 0);
      if (q0.size() > 0) bus.data0 = q0[0];
      if (q1.size() > 0) bus.data1 = q1[0];
      if (q0.size() == 0 && q1.size() == 0 && !bus.busy) begin
        to = 1'b0;
        return;
      end
    end
  endtask

  // With every request present from reset: lone requester wins, ties alternate starting at 0.
  task automatic predict();
    logic [7:0] a[$];
    logic [7:0] b[$];
    logic last, w;
    a = q0;
    b = q1;
    last = 1'b1;
    exp_byte.delete();
    exp_id.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) w = ~last;
      else w = (b.size() > 0);
      exp_id.push_back(w);
      if (w) exp_byte.push_back(b.pop_front());
      else exp_byte.push_back(a.pop_front());
      last = w;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.data0 = 8'hA5;
    bus.req1 = 1'b0; bus.data1 = 8'h00;
    repeat (3) @(negedge clk);
    vec++; if (bus.tx !== 1'b1) begin miss++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vec++; if (bus.ack0 !== 1'b0) begin miss++; $display("FAIL reset_ack0: got %b expected 0", bus.ack0); end
    vec++; if (bus.ack1 !== 1'b0) begin miss++; $display("FAIL reset_ack1: got %b expected 0", bus.ack1); end
    vec++; if (bus.grant_id !== 1'b0) begin miss++; $display("FAIL reset_grant_id: got %b expected 0", bus.grant_id); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack0 !== 1'b1 || bus.tx !== 1'b0) begin
      miss++; $display("FAIL first_grant: ack0=%b tx=%b expected ack0=1 tx=0", bus.ack0, bus.tx);
    end
    bus.req0 = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    vec++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      miss++; $display("FAIL async_abort: tx=%b busy=%b expected tx=1 busy=0", bus.tx, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic [9:0] bits;
    int bz, a0, a1, lg, base;
    do_reset();
    d = 8'hD3;
    bits = {1'b1, d, 1'b0};
    bz = 0; a0 = ack0_cnt; a1 = ack1_cnt; lg = ack_long; base = rx_byte.size();
    @(negedge clk);
    bus.data0 = d; bus.req0 = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack0 !== 1'b1) begin miss++; $display("FAIL single_ack_latency: ack0=%b expected 1", bus.ack0); end
    bus.req0 = 1'b0;
    for (int c = 0; c < 10 * BC + 20; c++) begin
      if (bus.busy) bz++;
      if ((c % BC) == BC / 2 && c / BC < 10) begin
        vec++; if (bus.tx !== bits[c / BC]) begin
          miss++; $display("FAIL single_bit%0d: tx=%b expected %b", c / BC, bus.tx, bits[c / BC]);
        end
      end
      @(negedge clk);
    end
    vec++; if (bz !== 10 * BC) begin miss++; $display("FAIL single_busy_len: got %0d expected %0d", bz, 10 * BC); end
    vec++; if (ack0_cnt - a0 !== 1) begin miss++; $display("FAIL single_ack0_count: got %0d expected 1", ack0_cnt - a0); end
    vec++; if (ack1_cnt - a1 !== 0 || ack_long - lg !== 0) begin
      miss++; $display("FAIL single_ack_shape: ack1=%0d long=%0d expected 0 0", ack1_cnt - a1, ack_long - lg);
    end
    vec++; if (rx_byte.size() - base !== 1) begin miss++; $display("FAIL single_frames: got %0d expected 1", rx_byte.size() - base); end
  endtask

  task automatic test_round_robin();
    int base; bit to;
    do_reset();
    base = rx_byte.size();
    q0.delete(); q1.delete();
    q0.push_back(8'h2C); q1.push_back(8'h9B);
    run_requesters(3 * FRAME, to);
    vec++; if (to) begin miss++; $display("FAIL rr_timeout: got timeout expected completion"); end
    vec++; if (rx_byte.size() - base !== 2) begin miss++; $display("FAIL rr_frames: got %0d expected 2", rx_byte.size() - base); end
    if (rx_byte.size() >= base + 2) begin
      vec++; if (rx_byte[base] !== 8'h2C || rx_id[base] !== 1'b0) begin
        miss++; $display("FAIL rr_first: got %h/id%b expected 2c/id0", rx_byte[base], rx_id[base]);
      end
      vec++; if (rx_byte[base+1] !== 8'h9B || rx_id[base+1] !== 1'b1) begin
        miss++; $display("FAIL rr_second: got %h/id%b expected 9b/id1", rx_byte[base+1], rx_id[base+1]);
      end
      vec++; if (rx_start[base+1] - rx_start[base] !== FRAME) begin
        miss++; $display("FAIL rr_spacing: got %0d expected %0d", rx_start[base+1] - rx_start[base], FRAME);
      end
    end
  endtask

  task automatic test_alternate(input int n0, input int n1, input string tag);
    int base, both; bit to;
    do_reset();
    base = rx_byte.size(); both = ack_both;
    q0.delete(); q1.delete();
    for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
    predict();
    run_requesters((n0 + n1 + 1) * FRAME, to);
    vec++; if (to) begin miss++; $display("FAIL %s_timeout: got timeout expected completion", tag); end
    vec++; if (ack_both - both !== 0) begin miss++; $display("FAIL %s_ack_overlap: got %0d expected 0", tag, ack_both - both); end
    vec++; if (rx_byte.size() - base !== exp_byte.size()) begin
      miss++; $display("FAIL %s_frames: got %0d expected %0d", tag, rx_byte.size() - base, exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size() && base + i < rx_byte.size(); i++) begin
      vec++; if (rx_byte[base+i] !== exp_byte[i] || rx_id[base+i] !== exp_id[i]) begin
        miss++; $display("FAIL %s_frame%0d: got %h/id%b expected %h/id%b", tag, i,
                         rx_byte[base+i], rx_id[base+i], exp_byte[i], exp_id[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, bad, a1, low; bit to;
    do_reset();
    base = rx_byte.size();
    @(negedge clk);
    bus.data1 = 8'hFF; bus.req1 = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack1 !== 1'b1) begin miss++; $display("FAIL rmid_ack: ack1=%b expected 1", bus.ack1); end
    bus.req1 = 1'b0;
    repeat (1998) @(negedge clk);
    vec++; if (bus.busy !== 1'b1 || bus.grant_id !== 1'b1) begin
      miss++; $display("FAIL rmid_inflight: busy=%b grant_id=%b expected 1 1", bus.busy, bus.grant_id);
    end
    rst = 1'b0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.grant_id !== 1'b0) bad++;
    end
    vec++; if (bad !== 0) begin miss++; $display("FAIL rmid_during_reset: got %0d bad cycles expected 0", bad); end
    rst = 1'b1; a1 = ack1_cnt; low = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) low++;
    end
    vec++; if (ack1_cnt - a1 !== 0) begin miss++; $display("FAIL rmid_stale_ack: got %0d expected 0", ack1_cnt - a1); end
    vec++; if (low !== 0) begin miss++; $display("FAIL rmid_tx_after: got %0d low cycles expected 0", low); end
    bus.data1 = 8'h5A; bus.req1 = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack1 !== 1'b1) begin miss++; $display("FAIL rmid_regrant: ack1=%b expected 1", bus.ack1); end
    bus.req1 = 1'b0;
    wait_idle(FRAME + 20, to);
    vec++; if (to) begin miss++; $display("FAIL rmid_timeout: got timeout expected idle"); end
    vec++; if (rx_byte.size() - base !== 1) begin miss++; $display("FAIL rmid_frames: got %0d expected 1", rx_byte.size() - base); end
    if (rx_byte.size() > base) begin
      vec++; if (rx_byte[base] !== 8'h5A || rx_id[base] !== 1'b1) begin
        miss++; $display("FAIL rmid_byte: got %h/id%b expected 5a/id1", rx_byte[base], rx_id[base]);
      end
    end
  endtask

  task automatic test_data_change();
    int base; bit to;
    do_reset();
    base = rx_byte.size();
    @(negedge clk);
    bus.data0 = 8'hEF; bus.req0 = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack0 !== 1'b1) begin miss++; $display("FAIL dchg_ack: ack0=%b expected 1", bus.ack0); end
    bus.req0 = 1'b0;
    repeat (2000) @(negedge clk);
    bus.data0 = 8'h00;
    wait_idle(FRAME, to);
    vec++; if (to) begin miss++; $display("FAIL dchg_timeout: got timeout expected idle"); end
    vec++; if (rx_byte.size() - base !== 1) begin miss++; $display("FAIL dchg_frames: got %0d expected 1", rx_byte.size() - base); end
    if (rx_byte.size() > base) begin
      vec++; if (rx_byte[base] !== 8'hEF) begin miss++; $display("FAIL dchg_byte: got %h expected ef", rx_byte[base]); end
    end
  endtask

  task automatic test_pulse();
    int base, a1; bit to;
    logic [7:0] d;
    do_reset();
    base = rx_byte.size(); a1 = ack1_cnt;
    d = 8'($urandom);
    @(negedge clk);
    bus.data0 = d; bus.req0 = 1'b1;
    @(negedge clk);
    vec++; if (bus.ack0 !== 1'b1) begin miss++; $display("FAIL pulse_ack0: ack0=%b expected 1", bus.ack0); end
    bus.req0 = 1'b0;
    repeat (1000) @(negedge clk);
    bus.data1 = 8'h77; bus.req1 = 1'b1;
    @(negedge clk);
    bus.req1 = 1'b0;
    wait_idle(FRAME, to);
    vec++; if (to) begin miss++; $display("FAIL pulse_timeout: got timeout expected idle"); end
    repeat (600) @(negedge clk);
    vec++; if (ack1_cnt - a1 !== 0) begin miss++; $display("FAIL pulse_ack1: got %0d expected 0", ack1_cnt - a1); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL pulse_busy_after: got %b expected 0", bus.busy); end
    vec++; if (rx_byte.size() - base !== 1) begin miss++; $display("FAIL pulse_frames: got %0d expected 1", rx_byte.size() - base); end
    if (rx_byte.size() > base) begin
      vec++; if (rx_byte[base] !== d || rx_id[base] !== 1'b0) begin
        miss++; $display("FAIL pulse_byte: got %h/id%b expected %h/id0", rx_byte[base], rx_id[base], d);
      end
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 8'h00; bus.data1 = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_alternate(2, 2, "alt");
    test_alternate(int'($urandom_range(2, 1)), int'($urandom_range(2, 0)), "rand");
    test_reset_mid();
    test_data_change();
    test_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
